mfp_ahb_cmd_master: RTL and testbench

MFP_AHB_CMD_MASTER -- requirements
Module: mfp_ahb_cmd_master

---
 rtl/mfp_ahb_cmd_master_pkg.sv | 11 +
 rtl/mfp_ahb_master_timeout.sv | 16 +
 rtl/mfp_ahb_cmd_master.sv | 97 +++++++++
 tb/tb_mfp_ahb_cmd_master.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mfp_ahb_cmd_master_pkg.sv
// mfp_ahb_cmd_master_pkg: AHB-Lite encodings and command legality check shared by the command master.
package mfp_ahb_cmd_master_pkg;
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HSIZE_HALF    = 3'b001;
   localparam logic [2:0] HSIZE_WORD    = 3'b010;
   function automatic logic cmd_bad(input logic [2:0] size, input logic [1:0] addr_lo);
      return size > HSIZE_WORD || (size == HSIZE_HALF && addr_lo[0]) || (size == HSIZE_WORD && addr_lo != 2'b00);
   endfunction
endpackage

// File: rtl/mfp_ahb_master_timeout.sv
// mfp_ahb_master_timeout: counts consecutive stalled data-phase cycles; hit marks the cycle that reaches TIMEOUT_CYCLES.
module mfp_ahb_master_timeout #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic HCLK,
   input  logic HRESETn,
   input  logic en,
   output logic hit
);
   localparam int W = $clog2(TIMEOUT_CYCLES + 1);
   logic [W-1:0] cnt;
   assign hit = en && cnt == W'(TIMEOUT_CYCLES - 1);
   always_ff @(posedge HCLK or negedge HRESETn)
      if (!HRESETn) cnt <= '0;
      else cnt <= en ? cnt + 1'b1 : '0;
endmodule

// File: rtl/mfp_ahb_cmd_master.sv
// mfp_ahb_cmd_master: turns single commands into AHB-Lite single transfers, one outstanding at a time.
// Define MFP_AHB_MASTER_TIMEOUT_EN to abort data phases stalled for TIMEOUT_CYCLES cycles.
module mfp_ahb_cmd_master
   import mfp_ahb_cmd_master_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   input  logic        cmd_write,
   input  logic [2:0]  cmd_size,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        rsp_timeout,
   output logic [31:0] HADDR,
   output logic [2:0]  HBURST,
   output logic        HMASTLOCK,
   output logic [3:0]  HPROT,
   output logic [2:0]  HSIZE,
   output logic [1:0]  HTRANS,
   output logic [31:0] HWDATA,
   output logic        HWRITE,
   input  logic [31:0] HRDATA,
   input  logic        HREADY,
   input  logic        HRESP
);
   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;
   localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;
   state_t state;
   logic   bad;
   assign bad       = cmd_bad(cmd_size, cmd_addr[1:0]);
   assign cmd_ready = state == S_IDLE;
   assign rsp_valid = state == S_RESP;
   assign HTRANS    = state == S_ADDR ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign HBURST    = HBURST_SINGLE;
   assign HMASTLOCK = 1'b0;
   assign HPROT     = HPROT_DATA_PRIV;
`ifdef MFP_AHB_MASTER_TIMEOUT_EN
   logic to_hit;
   mfp_ahb_master_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .HCLK(HCLK),
      .HRESETn(HRESETn),
      .en(state == S_DATA && !HREADY),
      .hit(to_hit)
   );
`else
   assign rsp_timeout = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif
   always_ff @(posedge HCLK or negedge HRESETn)
      if (!HRESETn) begin
         state     <= S_IDLE;
         HADDR     <= '0;
         HWDATA    <= '0;
         HWRITE    <= 1'b0;
         HSIZE     <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
`ifdef MFP_AHB_MASTER_TIMEOUT_EN
         rsp_timeout <= 1'b0;
`endif
      end else
         case (state)
            S_IDLE: if (cmd_valid) begin
               HADDR     <= cmd_addr;
               HWDATA    <= cmd_wdata;
               HWRITE    <= cmd_write;
               HSIZE     <= cmd_size;
               rsp_rdata <= '0;
               rsp_err   <= bad;
`ifdef MFP_AHB_MASTER_TIMEOUT_EN
               rsp_timeout <= 1'b0;
`endif
               state     <= bad ? S_RESP : S_ADDR;
            end
            S_ADDR: if (HREADY) state <= S_DATA;
            S_DATA: if (HREADY) begin
               rsp_err   <= HRESP;
               rsp_rdata <= (HRESP || HWRITE) ? '0 : HRDATA;
               state     <= S_RESP;
            end
`ifdef MFP_AHB_MASTER_TIMEOUT_EN
            else if (to_hit) begin
               rsp_err     <= 1'b1;
               rsp_timeout <= 1'b1;
               state       <= S_RESP;
            end
`endif
            S_RESP: if (rsp_ready) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
endmodule

// File: tb/tb_mfp_ahb_cmd_master.sv
// tb_mfp_ahb_cmd_master: directed self-checking bench for mfp_ahb_cmd_master.
// Define MFP_AHB_MASTER_TIMEOUT_EN to include the timeout scenario.
module tb_mfp_ahb_cmd_master;
   logic HCLK = 1'b0, HRESETn = 1'b0;
   logic cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b1;
   logic [31:0] cmd_addr = '0, cmd_wdata = '0, HRDATA = '0;
   logic [2:0] cmd_size = '0;
   logic HREADY = 1'b1, HRESP = 1'b0;
   logic cmd_ready, rsp_valid, rsp_err, rsp_timeout, HMASTLOCK, HWRITE;
   logic [31:0] rsp_rdata, HADDR, HWDATA;
   logic [2:0] HBURST, HSIZE;
   logic [3:0] HPROT;
   logic [1:0] HTRANS;
   int tests = 0, fails = 0, nonseq = 0;

   mfp_ahb_cmd_master #(.TIMEOUT_CYCLES(4)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata), .cmd_write(cmd_write), .cmd_size(cmd_size),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .HADDR(HADDR), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT),
      .HSIZE(HSIZE), .HTRANS(HTRANS), .HWDATA(HWDATA), .HWRITE(HWRITE),
      .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
   );

   always #5 HCLK = ~HCLK;
   always @(negedge HCLK) if (HTRANS === 2'b10) nonseq++;

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [2:0] s);
      cmd_valid = 1'b1; cmd_addr = a; cmd_wdata = d; cmd_write = w; cmd_size = s;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      HRESETn = 1'b0;
      repeat (3) tick();
      tests++; if (HTRANS !== 2'b00) begin fails++; $display("FAIL rst_htrans: got %h exp 0", HTRANS); end
      tests++; if (HADDR !== 32'h0 || HWDATA !== 32'h0) begin fails++; $display("FAIL rst_addr_wdata: got %h/%h exp 0/0", HADDR, HWDATA); end
      tests++; if ({HWRITE, HSIZE} !== 4'h0) begin fails++; $display("FAIL rst_write_size: got %b/%h exp 0/0", HWRITE, HSIZE); end
      tests++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b000 || rsp_rdata !== 32'h0) begin fails++; $display("FAIL rst_rsp: got v%b e%b t%b d%h exp all 0", rsp_valid, rsp_err, rsp_timeout, rsp_rdata); end
      tests++; if (HBURST !== 3'b000 || HMASTLOCK !== 1'b0 || HPROT !== 4'b0011) begin fails++; $display("FAIL rst_const: got burst %h lock %b prot %h exp 0/0/3", HBURST, HMASTLOCK, HPROT); end
      HRESETn = 1'b1;
      tick();
      tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL rst_cmd_ready: got %b exp 1", cmd_ready); end
   endtask

   task automatic test_zero_wait_write();
      int n0 = nonseq;
      tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL zw_ready: got %b exp 1", cmd_ready); end
      issue(32'h1F80_0000, 32'hA5A5_1234, 1'b1, 3'd2);
      tests++; if (HTRANS !== 2'b10 || HADDR !== 32'h1F80_0000 || HWRITE !== 1'b1 || HSIZE !== 3'd2) begin fails++; $display("FAIL zw_addr_phase: got t%h a%h w%b s%h exp 2/1f800000/1/2", HTRANS, HADDR, HWRITE, HSIZE); end
      tests++; if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin fails++; $display("FAIL zw_busy1: got ready %b valid %b exp 0/0", cmd_ready, rsp_valid); end
      tick();
      tests++; if (HTRANS !== 2'b00 || HWDATA !== 32'hA5A5_1234) begin fails++; $display("FAIL zw_data_phase: got t%h d%h exp 0/a5a51234", HTRANS, HWDATA); end
      tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL zw_early_valid: got %b exp 0", rsp_valid); end
      tick();
      tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin fails++; $display("FAIL zw_rsp: got v%b e%b d%h exp 1/0/0", rsp_valid, rsp_err, rsp_rdata); end
      tick();
      tests++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin fails++; $display("FAIL zw_back_idle: got v%b r%b exp 0/1", rsp_valid, cmd_ready); end
      tests++; if (nonseq - n0 !== 1) begin fails++; $display("FAIL zw_nonseq_count: got %0d exp 1", nonseq - n0); end
   endtask

   task automatic test_read_wait2();
      issue(32'h1F80_0010, 32'h1111_2222, 1'b0, 3'd2);
      tick();
      HREADY = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         tests++; if (HTRANS !== 2'b00 || HADDR !== 32'h1F80_0010 || HWDATA !== 32'h1111_2222 || rsp_valid !== 1'b0) begin fails++; $display("FAIL rd_wait%0d: got t%h a%h d%h v%b exp 0/1f800010/11112222/0", i, HTRANS, HADDR, HWDATA, rsp_valid); end
      end
      HREADY = 1'b1; HRDATA = 32'h0000_00FF;
      tick();
      HRDATA = 32'h0;
      tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_00FF || rsp_err !== 1'b0) begin fails++; $display("FAIL rd_rsp: got v%b d%h e%b exp 1/000000ff/0", rsp_valid, rsp_rdata, rsp_err); end
      tick();
   endtask

   task automatic test_error();
      int n0 = nonseq;
      issue(32'h2000_0000, 32'hDEAD_BEEF, 1'b1, 3'd2);
      tick();
      HRESP = 1'b1; HREADY = 1'b0;
      tick();
      tests++; if (rsp_valid !== 1'b0 || HTRANS !== 2'b00) begin fails++; $display("FAIL err_cycle1: got v%b t%h exp 0/0", rsp_valid, HTRANS); end
      HREADY = 1'b1;
      tick();
      HRESP = 1'b0;
      tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin fails++; $display("FAIL err_rsp: got v%b e%b exp 1/1", rsp_valid, rsp_err); end
      repeat (3) tick();
      tests++; if (nonseq - n0 !== 1) begin fails++; $display("FAIL err_no_retry: got %0d nonseq exp 1", nonseq - n0); end
   endtask

   task automatic test_reject();
      int n0 = nonseq;
      logic [34:0] vec [3] = '{{32'h1F80_0002, 3'd2}, {32'h1F80_0000, 3'd3}, {32'h1F80_0001, 3'd1}};
      for (int i = 0; i < 3; i++) begin
         issue(vec[i][34:3], 32'h5555_AAAA, 1'b1, vec[i][2:0]);
         tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || HTRANS !== 2'b00) begin fails++; $display("FAIL rej%0d: got v%b e%b t%h exp 1/1/0", i, rsp_valid, rsp_err, HTRANS); end
         tick();
      end
      tests++; if (nonseq - n0 !== 0) begin fails++; $display("FAIL rej_nonseq: got %0d exp 0", nonseq - n0); end
      issue(32'h1F80_0002, 32'h0, 1'b0, 3'd1);
      tests++; if (HTRANS !== 2'b10 || rsp_valid !== 1'b0) begin fails++; $display("FAIL half_ok: got t%h v%b exp 2/0", HTRANS, rsp_valid); end
      repeat (3) tick();
   endtask

   task automatic test_backpressure();
      rsp_ready = 1'b0;
      issue(32'h1F80_0020, 32'h0, 1'b0, 3'd2);
      HRDATA = 32'h1234_5678;
      tick();
      tick();
      HRDATA = 32'h0;
      cmd_valid = 1'b1; cmd_addr = 32'h1F80_0100; cmd_write = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234_5678 || rsp_err !== 1'b0 || cmd_ready !== 1'b0 || HTRANS !== 2'b00) begin fails++; $display("FAIL bp_hold%0d: got v%b d%h e%b r%b t%h exp 1/12345678/0/0/0", i, rsp_valid, rsp_rdata, rsp_err, cmd_ready, HTRANS); end
         tick();
      end
      cmd_valid = 1'b0; rsp_ready = 1'b1;
      tick();
      tests++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin fails++; $display("FAIL bp_release: got v%b r%b exp 0/1", rsp_valid, cmd_ready); end
   endtask

   task automatic test_reset_mid();
      int n0;
      issue(32'h1F80_0030, 32'hCAFE_F00D, 1'b1, 3'd2);
      tick();
      HREADY = 1'b0;
      tick();
      HRESETn = 1'b0;
      #1;
      tests++; if (HTRANS !== 2'b00 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || HWDATA !== 32'h0 || HADDR !== 32'h0) begin fails++; $display("FAIL rstmid_now: got t%h v%b r%b d%h a%h exp 0/0/1/0/0", HTRANS, rsp_valid, cmd_ready, HWDATA, HADDR); end
      tick();
      HRESETn = 1'b1; HREADY = 1'b1;
      n0 = nonseq;
      repeat (4) begin
         tick();
         tests++; if (rsp_valid !== 1'b0 || HTRANS !== 2'b00) begin fails++; $display("FAIL rstmid_quiet: got v%b t%h exp 0/0", rsp_valid, HTRANS); end
      end
      tests++; if (nonseq - n0 !== 0) begin fails++; $display("FAIL rstmid_nonseq: got %0d exp 0", nonseq - n0); end
   endtask

`ifdef MFP_AHB_MASTER_TIMEOUT_EN
   task automatic test_timeout();
      issue(32'h1F80_0040, 32'h0, 1'b0, 3'd2);
      tick();
      HREADY = 1'b0;
      repeat (3) tick();
      tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL to_early: got %b exp 0", rsp_valid); end
      tick();
      tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_timeout !== 1'b1) begin fails++; $display("FAIL to_rsp: got v%b e%b t%b exp 1/1/1", rsp_valid, rsp_err, rsp_timeout); end
      HREADY = 1'b1;
      tick();
      issue(32'h1F80_0044, 32'h0, 1'b0, 3'd2);
      tick();
      tick();
      tests++; if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b0 || rsp_err !== 1'b0) begin fails++; $display("FAIL to_clear: got v%b t%b e%b exp 1/0/0", rsp_valid, rsp_timeout, rsp_err); end
      tick();
   endtask
`else
   task automatic test_timeout();
      tests++; if (rsp_timeout !== 1'b0) begin fails++; $display("FAIL to_tied: got %b exp 0", rsp_timeout); end
   endtask
`endif

   initial begin
      test_reset();
      test_zero_wait_write();
      test_read_wait2();
      test_error();
      test_reject();
      test_backpressure();
      test_reset_mid();
      test_timeout();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
